// File: rtl/alu_unit_pkg.sv
// Shared RV32I decode constants and ALU helpers for alu_unit.
// Consumers: alu_core (datapath) and alu_unit (queue/handshake).
package alu_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // alt selects SUB for F3_ADD and SRA for F3_SR
  function automatic logic [XLEN-1:0] alu_op(
    input logic [2:0]      f3,
    input logic            alt,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      F3_ADD:  alu_op = alt ? a - b : a + b;
      F3_SLL:  alu_op = a << sh;
      F3_SLT:  alu_op = {{(XLEN-1){1'b0}},
                         $signed(a) < $signed(b)};
      F3_SLTU: alu_op = {{(XLEN-1){1'b0}}, a < b};
      F3_XOR:  alu_op = a ^ b;
      F3_SR:   alu_op = alt ? XLEN'($signed(a) >>> sh)
                            : a >> sh;
      F3_OR:   alu_op = a | b;
      default: alu_op = a & b;
    endcase
  endfunction

  function automatic logic br_taken(
    input logic [2:0]      f3,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    case (f3)
      F3_BEQ:  br_taken = a == b;
      F3_BNE:  br_taken = a != b;
      F3_BLT:  br_taken = $signed(a) < $signed(b);
      F3_BGE:  br_taken = $signed(a) >= $signed(b);
      F3_BLTU: br_taken = a < b;
      F3_BGEU: br_taken = a >= b;
      default: br_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_unit_core.sv
// alu_core: purely combinational RV32I integer datapath.
// Produces rd value, jump flag and next-PC target per instruction.
module alu_core
  import alu_unit_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] value,
  output logic            jump,
  output logic [XLEN-1:0] target
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            alt;
  logic [XLEN-1:0] seq_pc;
  logic            unused_bits;

  assign opc    = inst[6:0];
  assign f3     = inst[14:12];
  assign alt    = inst[30];
  assign seq_pc = pc + 32'd4;
  assign unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

  always_comb begin
    value  = '0;
    jump   = 1'b0;
    target = seq_pc;
    unique case (1'b1)
      opc == OPC_OP:
        value = alu_op(f3, alt, rs1, rs2);
      // inst[30] is an immediate bit except for SRAI
      opc == OPC_OPIMM:
        value = alu_op(f3, alt && f3 == F3_SR, rs1, imm);
      opc == OPC_LUI:
        value = imm;
      opc == OPC_AUIPC:
        value = pc + imm;
      opc == OPC_JAL: begin
        value  = seq_pc;
        jump   = 1'b1;
        target = pc + imm;
      end
      opc == OPC_JALR: begin
        value  = seq_pc;
        jump   = 1'b1;
        target = (rs1 + imm) & ~32'd1;
      end
      opc == OPC_BRANCH: begin
        jump = br_taken(f3, rs1, rs2);
        if (jump) target = pc + imm;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: issue-side ALU with in-order CDB output buffering.
// Define ALU_OUTQ_EN for an OQ_DEPTH queue; else one holding reg.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int TAG_W    = 5,
  parameter int OQ_DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             issue_valid,
  input  logic [XLEN-1:0]  issue_inst,
  input  logic [XLEN-1:0]  issue_pc,
  input  logic [XLEN-1:0]  issue_rs1_val,
  input  logic [XLEN-1:0]  issue_rs2_val,
  input  logic [XLEN-1:0]  issue_imme,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             alu_stall,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_value,
  output logic             cdb_jump,
  output logic [XLEN-1:0]  cdb_target
);

  localparam int EW = TAG_W + 2 * XLEN + 1;

  logic [XLEN-1:0] c_value;
  logic [XLEN-1:0] c_target;
  logic            c_jump;
  logic [EW-1:0]   ent_new;
  logic [EW-1:0]   head_ent;
  logic            accept;
  logic            pop;
  logic            ovf;

  alu_core u_core (
    .inst   (issue_inst),
    .pc     (issue_pc),
    .rs1    (issue_rs1_val),
    .rs2    (issue_rs2_val),
    .imm    (issue_imme),
    .value  (c_value),
    .jump   (c_jump),
    .target (c_target)
  );

  assign ent_new = {issue_tag, c_value, c_jump, c_target};
  // rst_in gating keeps alu_stall low while reset is held
  assign accept  = rst_in & rdy_in & issue_valid & ~clear;
  assign pop     = cdb_valid & cdb_grant & rdy_in;

`ifdef ALU_OUTQ_EN
  localparam int PW = (OQ_DEPTH > 1) ? $clog2(OQ_DEPTH) : 1;
  localparam int CW = $clog2(OQ_DEPTH + 1);
  localparam logic [PW-1:0] LAST  = PW'(OQ_DEPTH - 1);
  localparam logic [CW-1:0] FULL  = CW'(OQ_DEPTH);
  localparam logic [CW-1:0] HIWAT = CW'(OQ_DEPTH - 1);

  logic [EW-1:0] mem_q [OQ_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;

  assign push = accept & (count_q != FULL);
  assign ovf  = accept & (count_q == FULL);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (clear) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push)
          tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
        if (pop)
          head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < OQ_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) mem_q[tail_q] <= ent_new;
    end
  end

  assign cdb_valid = count_q != '0;
  assign head_ent  = mem_q[head_q];
  // one free slot absorbs the issue already in flight
  assign alu_stall = count_q >= HIWAT;
`else
  logic [EW-1:0] hold_q, hold_d;
  logic          valid_q, valid_d;

  assign ovf = accept & valid_q & ~pop;

  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    if (rdy_in) begin
      if (clear) begin
        valid_d = 1'b0;
      end else if (accept && !ovf) begin
        valid_d = 1'b1;
        hold_d  = ent_new;
      end else if (pop) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  assign cdb_valid = valid_q;
  assign head_ent  = hold_q;
  assign alu_stall = valid_q | accept;
`endif

  assign {cdb_tag, cdb_value, cdb_jump, cdb_target} =
    cdb_valid ? head_ent : '0;

  a_no_overflow: assert property (
    @(posedge clk_in) disable iff (!rst_in) !ovf
  );

endmodule
